// File: rtl/clk_div_pkg.sv
// Shared constants, FSM state type and boundary helper for the divided-clock controller.
package clk_div_pkg;

    localparam int NTAPS = 4;
    localparam int SELW  = 3;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    // Low (m+1) bits set: cnt matches this mask on the last cycle of a tap-m period.
    function automatic logic [31:0] boundary_mask(input int m);
        return (32'd1 << (m + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Free-running binary divider chain; bit k of the count is the divide-by-2^(k+1) tap.
module clk_div_counter #(
    parameter int NTAPS = clk_div_pkg::NTAPS
) (
    input  logic             clk,
    input  logic             rst,
    output logic [NTAPS-1:0] cnt,
    output logic [NTAPS-1:0] cnt_next
);

    logic [NTAPS-1:0] cnt_q;
    logic [NTAPS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + NTAPS'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock generator: selects one divider tap and switches tap/enable only at a
// boundary where both the old and the new tap fall together, so div_out never runts.
module clk_div_ctrl #(
    parameter int NTAPS = clk_div_pkg::NTAPS,
    parameter int SELW  = clk_div_pkg::SELW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [SELW-1:0] cfg_sel,
    input  logic            cfg_en,
    output logic            cfg_done,
    output logic            cfg_err,
    output logic [SELW-1:0] active_sel,
    output logic            active_en,
    output logic            div_out,
    output logic            div_tick
);

    import clk_div_pkg::*;

    if (NTAPS < 1 || NTAPS > 30 || (1 << SELW) <= NTAPS - 1) begin : g_param_check
        $error("clk_div_ctrl: SELW too narrow for NTAPS, or NTAPS out of range");
    end

    logic [NTAPS-1:0] cnt;
    logic [NTAPS-1:0] cnt_next;

    clk_div_counter #(
        .NTAPS(NTAPS)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .cnt     (cnt),
        .cnt_next(cnt_next)
    );

    state_e          state_q,      state_d;
    logic [SELW-1:0] active_sel_q, active_sel_d;
    logic            active_en_q,  active_en_d;
    logic [SELW-1:0] pend_sel_q,   pend_sel_d;
    logic            pend_en_q,    pend_en_d;
    logic            div_out_q,    div_out_d;
    logic            div_tick_q,   div_tick_d;
    logic            cfg_done_q,   cfg_done_d;
    logic            cfg_err_q,    cfg_err_d;

    logic [SELW-1:0]  max_sel;
    logic [NTAPS-1:0] bmask;
    logic             at_boundary;
    logic             sel_bad;
    logic             tap_bit;

    // The slower of the two taps sets the boundary; the faster one falls there too.
    always_comb begin
        max_sel     = (active_sel_q > pend_sel_q) ? active_sel_q : pend_sel_q;
        bmask       = NTAPS'(boundary_mask(int'(max_sel)));
        at_boundary = ((cnt & bmask) == bmask);
        sel_bad     = (int'(cfg_sel) >= NTAPS);
    end

    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        active_en_d  = active_en_q;
        pend_sel_d   = pend_sel_q;
        pend_en_d    = pend_en_q;
        cfg_done_d   = 1'b0;
        cfg_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (sel_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        pend_sel_d = cfg_sel;
                        pend_en_d  = cfg_en;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (at_boundary) begin
                    active_sel_d = pend_sel_q;
                    active_en_d  = pend_en_q;
                    cfg_done_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output follows the next count through the next selection: zero latency to cnt.
    always_comb begin
        tap_bit    = |(cnt_next & (NTAPS'(1) << active_sel_d));
        div_out_d  = active_en_d & tap_bit;
        div_tick_d = div_out_d & ~div_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            active_sel_q <= '0;
            active_en_q  <= 1'b1;
            pend_sel_q   <= '0;
            pend_en_q    <= 1'b0;
            div_out_q    <= 1'b0;
            div_tick_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            active_en_q  <= active_en_d;
            pend_sel_q   <= pend_sel_d;
            pend_en_q    <= pend_en_d;
            div_out_q    <= div_out_d;
            div_tick_q   <= div_tick_d;
            cfg_done_q   <= cfg_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_ready  = (state_q == IDLE);
    assign cfg_done   = cfg_done_q;
    assign cfg_err    = cfg_err_q;
    assign active_sel = active_sel_q;
    assign active_en  = active_en_q;
    assign div_out    = div_out_q;
    assign div_tick   = div_tick_q;

endmodule
